core_ctrl_axi_slave: RTL and testbench

//  AXI4 slave at the core-control end of the boot/reset path; the boot master writes it.

---
 rtl/core_ctrl_axi_slave_if.sv | 59 +++++
 rtl/core_ctrl_axi_slave.sv | 199 +++++++++++++++++++
 tb/tb_core_ctrl_axi_slave.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_axi_slave_if.sv
// rtl/core_ctrl_axi_slave_if.sv - AXI4 slave bus bundle for the core-control register block
interface core_ctrl_axi_slave_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 64
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // write address channel
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;

  // write data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  // write response channel
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // read address channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;

  // read data channel
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/core_ctrl_axi_slave.sv
// rtl/core_ctrl_axi_slave.sv - AXI4 slave holding one reset bit per RISC-V core for the boot master
module core_ctrl_axi_slave #(
  parameter int          DATA_WIDTH  = 64,
  parameter int          ADDR_WIDTH  = 19,
  parameter int          ID_WIDTH    = 8,
  parameter int          RISCV_CORES = 8,
  parameter logic [15:0] CTRL_OFFSET = 16'hFFF8
) (
  input  logic                   clk,
  input  logic                   rst,
  core_ctrl_axi_slave_if.slave   s_axi,
  output logic [RISCV_CORES-1:0] core_reset,
  output logic                   all_cores_released
);
  localparam int CORE_NO_WIDTH = $clog2(RISCV_CORES);
  localparam int STRB_WIDTH    = DATA_WIDTH / 8;
  // the reset bit is the lowest bit of the top byte lane
  localparam int RESET_BIT     = DATA_WIDTH - 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Length/framing errors outrank decode errors; the core field is range
  // checked in case RISCV_CORES is not a power of two.
  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic                  len_err);
    logic [1:0] resp;
    if (len_err)
      resp = RESP_SLVERR;
    else if (addr[15:0] != CTRL_OFFSET ||
             32'(addr[16 +: CORE_NO_WIDTH]) >= RISCV_CORES)
      resp = RESP_DECERR;
    else
      resp = RESP_OKAY;
    return resp;
  endfunction

  // A read beat carries the selected core's reset bit, or all zeros on error.
  function automatic logic [DATA_WIDTH-1:0] read_beat(input logic [ADDR_WIDTH-1:0]  addr,
                                                      input logic                   len_err,
                                                      input logic [RISCV_CORES-1:0] regs);
    logic [DATA_WIDTH-1:0] beat;
    beat = '0;
    if (decode_resp(addr, len_err) == RESP_OKAY)
      beat[RESET_BIT] = regs[addr[16 +: CORE_NO_WIDTH]];
    return beat;
  endfunction

  // ---------------------------------------------------------------- write side
  w_state_t                w_state;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [7:0]              w_cnt;
  logic                    w_last_err;
  logic [CORE_NO_WIDTH-1:0] w_core;
  logic                    w_is_last;
  logic                    w_beat_last_err;
  logic                    w_len_err;
  logic [1:0]              w_resp;

  // Classify the current W beat: wlast is only checked against the beat count.
  always_comb begin
    w_core          = aw_addr[16 +: CORE_NO_WIDTH];
    w_is_last       = (w_cnt == aw_len);
    w_beat_last_err = (s_axi.wlast != w_is_last);
    w_len_err       = (aw_len != 8'd0) || w_last_err || w_beat_last_err;
    w_resp          = decode_resp(aw_addr, w_len_err);
  end

  // Write FSM; the reset register updates on the final W handshake so the new
  // value is visible in the same cycle bvalid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bid     <= '0;
      s_axi.bresp   <= RESP_OKAY;
      aw_id         <= '0;
      aw_addr       <= '0;
      aw_len        <= '0;
      w_cnt         <= '0;
      w_last_err    <= 1'b0;
      core_reset    <= '1;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi.awready && s_axi.awvalid) begin
            aw_id         <= s_axi.awid;
            aw_addr       <= s_axi.awaddr;
            aw_len        <= s_axi.awlen;
            w_cnt         <= '0;
            w_last_err    <= 1'b0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi.awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (s_axi.wvalid && s_axi.wready) begin
            if (w_is_last) begin
              s_axi.wready <= 1'b0;
              s_axi.bvalid <= 1'b1;
              s_axi.bid    <= aw_id;
              s_axi.bresp  <= w_resp;
              if (w_resp == RESP_OKAY && s_axi.wstrb[STRB_WIDTH-1])
                core_reset[w_core] <= s_axi.wdata[RESET_BIT];
              w_state      <= W_RESP;
            end else begin
              w_cnt      <= w_cnt + 8'd1;
              w_last_err <= w_last_err | w_beat_last_err;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bvalid && s_axi.bready) begin
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [7:0]            r_cnt;

  // Read FSM; each beat samples core_reset when it is loaded, so a write landing
  // in the same cycle is seen by the following beat, not this one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rid     <= '0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
      s_axi.rlast   <= 1'b0;
      ar_addr       <= '0;
      ar_len        <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi.arready && s_axi.arvalid) begin
            ar_addr       <= s_axi.araddr;
            ar_len        <= s_axi.arlen;
            r_cnt         <= '0;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b1;
            s_axi.rid     <= s_axi.arid;
            s_axi.rresp   <= decode_resp(s_axi.araddr, s_axi.arlen != 8'd0);
            s_axi.rdata   <= read_beat(s_axi.araddr, s_axi.arlen != 8'd0, core_reset);
            s_axi.rlast   <= (s_axi.arlen == 8'd0);
            r_state       <= R_DATA;
          end else begin
            s_axi.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rvalid && s_axi.rready) begin
            if (s_axi.rlast) begin
              s_axi.rvalid  <= 1'b0;
              s_axi.rlast   <= 1'b0;
              s_axi.arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_cnt         <= r_cnt + 8'd1;
              s_axi.rlast   <= (8'(r_cnt + 8'd1) == ar_len);
              s_axi.rdata   <= read_beat(ar_addr, ar_len != 8'd0, core_reset);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Release flag trails core_reset by one register stage.
  always_ff @(posedge clk) begin
    if (rst)
      all_cores_released <= 1'b0;
    else
      all_cores_released <= (core_reset == '0);
  end
endmodule

// File: tb/tb_core_ctrl_axi_slave.sv
// tb/tb_core_ctrl_axi_slave.sv - directed plus randomized bench for core_ctrl_axi_slave
module tb_core_ctrl_axi_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] core_reset;
  logic       all_cores_released;

  core_ctrl_axi_slave_if #(.ID_WIDTH(8), .ADDR_WIDTH(19), .DATA_WIDTH(64)) bus ();

  core_ctrl_axi_slave dut (
    .clk                (clk),
    .rst                (rst),
    .s_axi              (bus),
    .core_reset         (core_reset),
    .all_cores_released (all_cores_released)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] mdl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] mk_addr(input int core, input logic [15:0] off);
    logic [2:0] c;
    c = 3'(core);
    return {c, off};
  endfunction

  // Response rules: length/framing error first, then address decode, else OKAY.
  function automatic logic [1:0] exp_resp(input logic [18:0] addr, input logic [7:0] len,
                                          input bit last_ok);
    if (len != 8'd0 || !last_ok) return 2'b10;
    if (addr[15:0] != 16'hFFF8 || int'(addr[18:16]) >= 8) return 2'b11;
    return 2'b00;
  endfunction

  task automatic axi_write(input string tag, input logic [18:0] addr, input logic [7:0] len,
                           input logic [63:0] data, input logic [7:0] strb,
                           input bit bad_last, input bit w_early, input bit skip_b);
    logic [7:0] id;
    logic [1:0] er;
    int         t;
    id = 8'($urandom);
    er = exp_resp(addr, len, !bad_last);
    if (w_early) begin
      bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
      bus.wlast  = (len == 8'd0) ^ bad_last;
      tick();
      check({tag, "_wstall"}, bus.wready, 1'b0);
    end
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = len;
    t = 0;
    while (!bus.awready && t < 50) begin tick(); t++; end
    check({tag, "_awready"}, bus.awready, 1'b1);
    tick();
    bus.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
      bus.wlast  = (b == int'(len)) ^ bad_last;
      t = 0;
      while (!bus.wready && t < 50) begin tick(); t++; end
      check({tag, "_wready"}, bus.wready, 1'b1);
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    if (er == 2'b00 && strb[7]) mdl[addr[18:16]] = data[56];
    check({tag, "_bvalid_lat"}, bus.bvalid, 1'b1);
    check({tag, "_core_reset"}, core_reset, mdl);
    if (skip_b) return;
    repeat ($urandom_range(0, 2)) begin
      tick();
      check({tag, "_bhold"}, bus.bvalid, 1'b1);
    end
    check({tag, "_bid"}, bus.bid, id);
    check({tag, "_bresp"}, bus.bresp, er);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check({tag, "_bdrop"}, bus.bvalid, 1'b0);
  endtask

  task automatic axi_read(input string tag, input logic [18:0] addr, input logic [7:0] len);
    logic [7:0]  id;
    logic [1:0]  er;
    logic [63:0] ed;
    int          t;
    id = 8'($urandom);
    er = exp_resp(addr, len, 1'b1);
    ed = (er == 2'b00) ? (64'(mdl[addr[18:16]]) << 56) : 64'd0;
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = len;
    t = 0;
    while (!bus.arready && t < 50) begin tick(); t++; end
    check({tag, "_arready"}, bus.arready, 1'b1);
    tick();
    bus.arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom_range(0, 1) == 1) tick();
      check({tag, "_rvalid"}, bus.rvalid, 1'b1);
      check({tag, "_rid"}, bus.rid, id);
      check({tag, "_rdata"}, bus.rdata, ed);
      check({tag, "_rresp"}, bus.rresp, er);
      check({tag, "_rlast"}, bus.rlast, b == int'(len));
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
    end
    check({tag, "_rdrop"}, bus.rvalid, 1'b0);
  endtask

  initial begin
    int t;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.rready = 0;
    mdl = 8'hFF;

    // reset state
    repeat (3) tick();
    check("rst_core_reset", core_reset, 8'hFF);
    check("rst_released", all_cores_released, 1'b0);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_wready", bus.wready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_awready", bus.awready, 1'b1);
    check("post_rst_arready", bus.arready, 1'b1);

    // status read of core 3 straight out of reset
    axi_read("rd_core3", mk_addr(3, 16'hFFF8), 8'd0);

    // release core 2
    axi_write("wr_core2", mk_addr(2, 16'hFFF8), 8'd0, 64'd0, 8'h80, 0, 0, 0);
    check("core2_value", core_reset, 8'hFB);

    // release every core with W presented ahead of AW
    for (int c = 0; c < 8; c++) begin
      axi_write("rel", mk_addr(c, 16'hFFF8), 8'd0, 64'd0, 8'h80, 0, 1, 0);
      check("rel_released", all_cores_released, mdl == 8'd0);
    end
    check("all_released", all_cores_released, 1'b1);

    // burst length errors
    axi_write("wr_len3", mk_addr(4, 16'hFFF8), 8'd3, 64'h0100_0000_0000_0000, 8'hFF, 0, 0, 0);
    axi_read("rd_len1", mk_addr(4, 16'hFFF8), 8'd1);
    // decode error and masked lane
    axi_write("wr_fff0", mk_addr(5, 16'hFFF0), 8'd0, 64'h0100_0000_0000_0000, 8'hFF, 0, 0, 0);
    axi_write("wr_strb7f", mk_addr(5, 16'hFFF8), 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h7F, 0, 0, 0);
    check("masked_unchanged", core_reset, 8'h00);
    // wlast missing on a single-beat burst
    axi_write("wr_badlast", mk_addr(6, 16'hFFF8), 8'd0, 64'h0100_0000_0000_0000, 8'h80, 1, 0, 0);
    axi_read("rd_core6", mk_addr(6, 16'hFFF8), 8'd0);

    // randomized mix against the model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] off;
      logic [7:0]  len;
      int          core;
      core = $urandom_range(0, 7);
      off  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'hFFF8;
      len  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
      if ($urandom_range(0, 1) == 1)
        axi_write("rnd_wr", mk_addr(core, off), len, {32'($urandom), 32'($urandom)},
                  {1'($urandom_range(0, 4) != 0), 7'($urandom)},
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 0);
      else
        axi_read("rnd_rd", mk_addr(core, off), len);
      check("rnd_released", all_cores_released, mdl == 8'd0);
    end

    // reset in the middle of a two-beat write
    bus.awvalid = 1'b1; bus.awid = 8'h5A; bus.awaddr = mk_addr(5, 16'hFFF8); bus.awlen = 8'd1;
    t = 0;
    while (!bus.awready && t < 50) begin tick(); t++; end
    check("mid_awready", bus.awready, 1'b1);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 64'd0; bus.wstrb = 8'h80; bus.wlast = 1'b0;
    tick();
    bus.wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl = 8'hFF;
    check("mid_bvalid", bus.bvalid, 1'b0);
    check("mid_core_reset", core_reset, 8'hFF);
    repeat (3) tick();
    check("mid_bvalid_later", bus.bvalid, 1'b0);

    // reset while a response is pending with bready low
    axi_write("pend", mk_addr(1, 16'hFFF8), 8'd0, 64'd0, 8'h80, 0, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl = 8'hFF;
    check("pend_bvalid", bus.bvalid, 1'b0);
    check("pend_core_reset", core_reset, 8'hFF);
    tick();
    check("pend_bvalid_later", bus.bvalid, 1'b0);

    // next write after reset goes through normally
    axi_write("after_rst", mk_addr(7, 16'hFFF8), 8'd0, 64'd0, 8'h80, 0, 0, 0);
    check("after_rst_value", core_reset, 8'h7F);
    axi_read("after_rst_rd", mk_addr(7, 16'hFFF8), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
